fetch_pc_unit: RTL and testbench

//  Fetch-side consumer of the branch decoder's pc_src. Holds the architectural fetch PC.

---
 rtl/fetch_pc_unit_if.sv | 27 ++
 rtl/fetch_pc_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response channel between the fetch PC unit (master)
// and the instruction memory (slave): valid/ready request, strobed response.
interface fetch_pc_unit_if #(
   parameter int Width = 32
);
   logic             inst_req_valid;
   logic             inst_req_ready;
   logic [Width-1:0] inst_req_addr;
   logic             inst_resp_valid;
   logic [Width-1:0] inst_resp_data;

   modport master (
      output inst_req_valid,
      output inst_req_addr,
      input  inst_req_ready,
      input  inst_resp_valid,
      input  inst_resp_data
   );

   modport slave (
      input  inst_req_valid,
      input  inst_req_addr,
      output inst_req_ready,
      output inst_resp_valid,
      output inst_resp_data
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-side PC holder: issues one outstanding instruction fetch at a time, applies
// pc_src redirects, drops responses made stale by a redirect, and fills the decode slot.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no request in flight; launch one once the decode slot frees up
// REQ     | request presented, waiting for inst_req_ready
// WAIT    | request accepted, waiting for its response
// DISCARD | request accepted but redirected since; drop its response
module fetch_pc_unit #(
   parameter int               Width       = 32,
   parameter logic [Width-1:0] ResetVector = '0,
   parameter int               InstBytes   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              redirect_en,
   input  logic [1:0]        pc_src,
   input  logic [Width-1:0]  mepc,
   input  logic [Width-1:0]  sepc,
   input  logic [Width-1:0]  branch_target,
   input  logic              stall,
   output logic              flush,
   fetch_pc_unit_if.master   imem,
   output logic              if_valid,
   output logic [Width-1:0]  if_pc,
   output logic [Width-1:0]  if_inst
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t           state;
   logic [Width-1:0] pc;
   logic             req_valid_q;
   logic [Width-1:0] req_addr_q;
   logic             redirect_pending;
   logic             if_valid_q;
   logic [Width-1:0] if_pc_q;
   logic [Width-1:0] if_inst_q;
   logic [Width-1:0] redirect_raw;
   logic [Width-1:0] redirect_target;

   assign flush = redirect_en & (|pc_src);

   always_comb begin
      redirect_raw = branch_target;
      case (pc_src)
         2'b01:   redirect_raw = mepc;
         2'b10:   redirect_raw = sepc;
         default: redirect_raw = branch_target;
      endcase
      redirect_target = {redirect_raw[Width-1:1], 1'b0};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         pc               <= ResetVector;
         req_valid_q      <= 1'b0;
         req_addr_q       <= '0;
         redirect_pending <= 1'b0;
         if_valid_q       <= 1'b0;
         if_pc_q          <= '0;
         if_inst_q        <= '0;
      end else begin
         // Slot empties on a flush or when decode takes it; a WAIT response below wins.
         if (flush || !stall) begin
            if_valid_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               // A redirect here only moves pc; the fetch launches next cycle from the new pc.
               if (flush) begin
                  pc <= redirect_target;
               end else if (!if_valid_q || !stall) begin
                  state       <= REQ;
                  req_valid_q <= 1'b1;
                  req_addr_q  <= pc;
               end
            end

            REQ: begin
               if (imem.inst_req_ready) begin
                  req_valid_q      <= 1'b0;
                  redirect_pending <= 1'b0;
                  if (flush) begin
                     pc    <= redirect_target;
                     state <= DISCARD;
                  end else if (redirect_pending) begin
                     state <= DISCARD;
                  end else begin
                     pc    <= pc + Width'(InstBytes);
                     state <= WAIT;
                  end
               end else if (flush) begin
                  // The request stays on the bus; remember that its response is stale.
                  pc               <= redirect_target;
                  redirect_pending <= 1'b1;
               end
            end

            WAIT: begin
               if (flush) begin
                  pc    <= redirect_target;
                  state <= imem.inst_resp_valid ? IDLE : DISCARD;
               end else if (imem.inst_resp_valid) begin
                  if_valid_q <= 1'b1;
                  if_pc_q    <= req_addr_q;
                  if_inst_q  <= imem.inst_resp_data;
                  state      <= IDLE;
               end
            end

            DISCARD: begin
               if (flush) begin
                  pc <= redirect_target;
               end
               if (imem.inst_resp_valid) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign imem.inst_req_valid = req_valid_q;
   assign imem.inst_req_addr  = req_addr_q;
   assign if_valid            = if_valid_q;
   assign if_pc               = if_pc_q;
   assign if_inst             = if_inst_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, backpressure, redirects, stall, mid-run reset.
module tb_fetch_pc_unit;
   localparam int Width = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic              redirect_en;
   logic [1:0]        pc_src;
   logic [Width-1:0]  mepc;
   logic [Width-1:0]  sepc;
   logic [Width-1:0]  branch_target;
   logic              stall;
   logic              flush;
   logic              if_valid;
   logic [Width-1:0]  if_pc;
   logic [Width-1:0]  if_inst;

   int n_cmp  = 0;
   int n_fail = 0;

   fetch_pc_unit_if #(.Width(Width)) imem ();

   fetch_pc_unit #(
      .Width       (Width),
      .ResetVector (32'h0000_0100),
      .InstBytes   (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .redirect_en   (redirect_en),
      .pc_src        (pc_src),
      .mepc          (mepc),
      .sepc          (sepc),
      .branch_target (branch_target),
      .stall         (stall),
      .flush         (flush),
      .imem          (imem.master),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts with a request sampled on the bus; ends one cycle after the slot fills.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
      chk("req_valid", 32'(imem.inst_req_valid), 32'd1);
      chk("req_addr", imem.inst_req_addr, addr);
      imem.inst_req_ready = 1'b1;
      tick();
      imem.inst_req_ready = 1'b0;
      chk("req_drop", 32'(imem.inst_req_valid), 32'd0);
      imem.inst_resp_valid = 1'b1;
      imem.inst_resp_data  = data;
      tick();
      imem.inst_resp_valid = 1'b0;
      chk("if_valid", 32'(if_valid), 32'd1);
      chk("if_pc", if_pc, addr);
      chk("if_inst", if_inst, data);
      chk("flush_idle", 32'(flush), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      redirect_en = 1'b0;
      pc_src = 2'b00;
      mepc = '0;
      sepc = '0;
      branch_target = '0;
      stall = 1'b0;
      imem.inst_req_ready  = 1'b0;
      imem.inst_resp_valid = 1'b0;
      imem.inst_resp_data  = '0;
      tick();
      tick();
      chk("rst_req_valid", 32'(imem.inst_req_valid), 32'd0);
      chk("rst_req_addr", imem.inst_req_addr, 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);

      // Sequential fetch
      reset = 1'b0;
      tick();
      do_fetch(32'h100, 32'hA000_0000);
      tick();
      chk("consume", 32'(if_valid), 32'd0);
      do_fetch(32'h104, 32'hA000_0001);
      tick();
      do_fetch(32'h108, 32'hA000_0002);
      tick();

      // Backpressure in REQ
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", 32'(imem.inst_req_valid), 32'd1);
         chk("bp_addr", imem.inst_req_addr, 32'h10C);
      end
      do_fetch(32'h10C, 32'hA000_0003);
      tick();

      // Taken branch during WAIT
      chk("pre_br_addr", imem.inst_req_addr, 32'h110);
      imem.inst_req_ready = 1'b1;
      tick();
      imem.inst_req_ready = 1'b0;
      redirect_en = 1'b1;
      pc_src = 2'b11;
      branch_target = 32'h2001;
      #1;
      chk("br_flush", 32'(flush), 32'd1);
      tick();
      redirect_en = 1'b0;
      #1;
      chk("br_flush_off", 32'(flush), 32'd0);
      imem.inst_resp_valid = 1'b1;
      imem.inst_resp_data  = 32'hDEAD_0000;
      tick();
      imem.inst_resp_valid = 1'b0;
      chk("br_drop", 32'(if_valid), 32'd0);
      tick();
      do_fetch(32'h2000, 32'hB000_0000);
      tick();

      // mret redirect while the request is still pending
      redirect_en = 1'b1;
      pc_src = 2'b01;
      mepc = 32'h81;
      tick();
      redirect_en = 1'b0;
      chk("mret_hold_valid", 32'(imem.inst_req_valid), 32'd1);
      chk("mret_hold_addr", imem.inst_req_addr, 32'h2004);
      imem.inst_req_ready = 1'b1;
      tick();
      imem.inst_req_ready = 1'b0;
      imem.inst_resp_valid = 1'b1;
      imem.inst_resp_data  = 32'hDEAD_0001;
      tick();
      imem.inst_resp_valid = 1'b0;
      chk("mret_drop", 32'(if_valid), 32'd0);
      tick();
      do_fetch(32'h80, 32'hC000_0000);
      tick();

      // sret redirect in the same cycle as accept
      chk("pre_sret_addr", imem.inst_req_addr, 32'h84);
      imem.inst_req_ready = 1'b1;
      redirect_en = 1'b1;
      pc_src = 2'b10;
      sepc = 32'h40;
      tick();
      imem.inst_req_ready = 1'b0;
      redirect_en = 1'b0;
      imem.inst_resp_valid = 1'b1;
      imem.inst_resp_data  = 32'hDEAD_0002;
      tick();
      imem.inst_resp_valid = 1'b0;
      chk("sret_drop", 32'(if_valid), 32'd0);
      tick();
      do_fetch(32'h40, 32'hD000_0000);

      // pc_src without redirect_en does nothing
      pc_src = 2'b11;
      branch_target = 32'h3000;
      #1;
      chk("noen_flush", 32'(flush), 32'd0);
      tick();
      pc_src = 2'b00;
      do_fetch(32'h44, 32'hD000_0001);

      // Stall holds the slot and blocks new requests
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_valid", 32'(if_valid), 32'd1);
         chk("stall_pc", if_pc, 32'h44);
         chk("stall_inst", if_inst, 32'hD000_0001);
         chk("stall_noreq", 32'(imem.inst_req_valid), 32'd0);
      end
      redirect_en = 1'b1;
      pc_src = 2'b11;
      branch_target = 32'h500;
      tick();
      redirect_en = 1'b0;
      stall = 1'b0;
      chk("stall_flush_valid", 32'(if_valid), 32'd0);
      chk("stall_flush_noreq", 32'(imem.inst_req_valid), 32'd0);
      tick();
      chk("stall_redir_addr", imem.inst_req_addr, 32'h500);
      chk("stall_redir_valid", 32'(imem.inst_req_valid), 32'd1);

      // Reset in WAIT
      imem.inst_req_ready = 1'b1;
      tick();
      imem.inst_req_ready = 1'b0;
      reset = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(imem.inst_req_valid), 32'd0);
      chk("mid_rst_addr", imem.inst_req_addr, 32'd0);
      chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
      chk("mid_rst_if_pc", if_pc, 32'd0);
      reset = 1'b0;
      pc_src = 2'b00;
      imem.inst_resp_valid = 1'b1;
      imem.inst_resp_data  = 32'hDEAD_0003;
      tick();
      imem.inst_resp_valid = 1'b0;
      chk("late_resp_drop", 32'(if_valid), 32'd0);
      do_fetch(32'h100, 32'hE000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
